// File: rtl/mul_div_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states
// and helpers that classify operand signedness.
package mul_div_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // MUL returns the low half, which is identical for signed and unsigned
    // operands, so it is treated as unsigned.
    function automatic logic op_a_signed(op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mul_div_if.sv
// Request/writeback bundle between the core pipeline and the mul/div unit.
// Handshake: start is sampled only while busy is low; wb_en is a one-cycle strobe.
interface mul_div_if #(
    parameter int XLEN = 32,
    parameter int RS   = 5
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [RS-1:0]   rd_in;
    logic            busy;
    logic            wb_en;
    logic [RS-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        output start, flush, funct3, op_a, op_b, rd_in,
        input  busy, wb_en, wb_rd, wb_data
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b, rd_in,
        output busy, wb_en, wb_rd, wb_data
    );
endinterface

// File: rtl/div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step, MSB first.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);
    logic [XLEN-1:0] quo_q, rem_q, div_q;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            borrow;

    // The quotient register doubles as the dividend shift register.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        borrow  = shifted < {1'b0, div_q};
        diff    = shifted[XLEN-1:0] - div_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
        end else if (load_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            div_q <= divisor_i;
        end else if (step_i) begin
            quo_q <= {quo_q[XLEN-2:0], ~borrow};
            rem_q <= borrow ? shifted[XLEN-1:0] : diff;
        end
    end

    assign quo_o = quo_q;
    assign rem_o = rem_q;
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M-style multiply/divide unit with fixed XLEN-cycle latency,
// shift-add multiplier, sign fix-up and divide special-case handling.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RS   = 5
) (
    input  logic      clk,
    input  logic      rst,
    mul_div_if.slave  bus,
    output state_e    state_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    state_e            state_q;
    op_e               op_q, op_in;
    logic [CW-1:0]     count_q;
    logic              busy_q;
    logic [RS-1:0]     rd_q, wb_rd_q;
    logic [XLEN-1:0]   a_q, b_q, wb_data_q;
    logic [2*XLEN:0]   prod_q, prod_step;

    logic              accept, in_a_neg, in_b_neg, a_neg, b_neg, ovf;
    logic [XLEN-1:0]   in_mag_a, in_mag_b, mag_a, quo_mag, rem_mag, quo_s, rem_s, result;
    logic [XLEN:0]     psum;
    logic [2*XLEN-1:0] prod_s;

    always_comb begin
        op_in    = op_e'(bus.funct3);
        accept   = bus.start && !bus.flush;
        in_a_neg = op_a_signed(op_in) && bus.op_a[XLEN-1];
        in_b_neg = op_b_signed(op_in) && bus.op_b[XLEN-1];
        in_mag_a = in_a_neg ? -bus.op_a : bus.op_a;
        in_mag_b = in_b_neg ? -bus.op_b : bus.op_b;
        a_neg    = op_a_signed(op_q) && a_q[XLEN-1];
        b_neg    = op_b_signed(op_q) && b_q[XLEN-1];
        mag_a    = a_neg ? -a_q : a_q;
        // Upper XLEN+1 bits accumulate the partial product; lower half shifts out the multiplier.
        psum      = prod_q[2*XLEN:XLEN] + (prod_q[0] ? {1'b0, mag_a} : '0);
        prod_step = {psum, prod_q[XLEN-1:0]} >> 1;
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == S_IDLE && accept),
        .step_i     (state_q == S_CALC && !bus.flush),
        .dividend_i (in_mag_a),
        .divisor_i  (in_mag_b),
        .quo_o      (quo_mag),
        .rem_o      (rem_mag)
    );

    always_comb begin
        prod_s = (a_neg ^ b_neg) ? -prod_q[2*XLEN-1:0] : prod_q[2*XLEN-1:0];
        quo_s  = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
        rem_s  = a_neg ? -rem_mag : rem_mag;
        ovf    = (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
        result = '0;
        case (op_q)
            OP_MUL:                       result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (b_q == '0)                 result = '1;
                else if (op_q == OP_DIV && ovf) result = a_q;
                else                           result = quo_s;
            end
            default: begin
                if (b_q == '0)                 result = a_q;
                else if (op_q == OP_REM && ovf) result = '0;
                else                           result = rem_s;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MUL;
            count_q   <= '0;
            busy_q    <= 1'b0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wb_data_q <= '0;
            prod_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (accept) begin
                    state_q <= S_CALC;
                    count_q <= '0;
                    busy_q  <= 1'b1;
                    op_q    <= op_in;
                    rd_q    <= bus.rd_in;
                    a_q     <= bus.op_a;
                    b_q     <= bus.op_b;
                    prod_q  <= {{(XLEN+1){1'b0}}, in_mag_b};
                end
                S_CALC: if (bus.flush) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    prod_q  <= prod_step;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (!bus.flush) begin
                        wb_rd_q   <= rd_q;
                        wb_data_q <= result;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Result is presented live during DONE and held in wb_*_q afterwards.
    assign bus.busy    = busy_q;
    assign bus.wb_en   = (state_q == S_DONE) && !bus.flush && !rst;
    assign bus.wb_rd   = (state_q == S_DONE) ? rd_q : wb_rd_q;
    assign bus.wb_data = (state_q == S_DONE) ? result : wb_data_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus flush/ignore/reset sequences.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    localparam int XLEN = 32;
    localparam int RS   = 5;

    logic   clk;
    logic   rst;
    state_e dbg_state;
    int     errors = 0;
    int     checks = 0;
    logic [XLEN-1:0] last_data = '0;
    logic [RS-1:0]   last_rd   = '0;

    mul_div_if #(.XLEN(XLEN), .RS(RS)) bus ();

    mul_div_unit #(.XLEN(XLEN), .RS(RS)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]      f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RS-1:0]   rd;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [RS-1:0] rd);
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Counts edges after the accept edge until wb_en is seen; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.wb_en && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input int id, input logic [2:0] f, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [RS-1:0] rd,
                          input logic [XLEN-1:0] exp);
        int n;
        issue(f, a, b, rd);
        wait_done(n);
        chk($sformatf("v%0d latency", id), 64'(n), 64'(XLEN));
        chk($sformatf("v%0d wb_data", id), 64'(bus.wb_data), 64'(exp));
        chk($sformatf("v%0d wb_rd", id), 64'(bus.wb_rd), 64'(rd));
        chk($sformatf("v%0d busy_done", id), 64'(bus.busy), 64'(1));
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d wb_en_pulse", id), 64'(bus.wb_en), 64'(0));
        chk($sformatf("v%0d busy_after", id), 64'(bus.busy), 64'(0));
        chk($sformatf("v%0d data_hold", id), 64'(bus.wb_data), 64'(exp));
        chk($sformatf("v%0d rd_hold", id), 64'(bus.wb_rd), 64'(rd));
        last_data = exp;
        last_rd   = rd;
    endtask

    initial begin
        int n;
        int wb_seen;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,        5'd5,  32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd5,        32'd0,        5'd7,  32'hFFFF_FFFF};
        vecs[7]  = '{3'd7, 32'd5,        32'd0,        5'd8,  32'd5};
        vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000};
        vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000};
        vecs[10] = '{3'd4, 32'd100,      32'd0,        5'd11, 32'hFFFF_FFFF};
        vecs[11] = '{3'd6, 32'hFFFF_FFFB, 32'd0,        5'd12, 32'hFFFF_FFFB};
        vecs[12] = '{3'd5, 32'hFFFF_FFFF, 32'd3,        5'd13, 32'h5555_5555};
        vecs[13] = '{3'd7, 32'd100,      32'd7,        5'd14, 32'd2};
        vecs[14] = '{3'd0, 32'h1234_5678, 32'h10,       5'd0,  32'h2345_6780};
        vecs[15] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd15, 32'h4000_0000};
        vecs[16] = '{3'd6, 32'd7,        32'hFFFF_FFFE, 5'd16, 32'd1};

        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
        bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 64'(bus.busy), 64'(0));
        chk("rst wb_en", 64'(bus.wb_en), 64'(0));
        chk("rst wb_rd", 64'(bus.wb_rd), 64'(0));
        chk("rst wb_data", 64'(bus.wb_data), 64'(0));
        chk("rst state", 64'(dbg_state), 64'(S_IDLE));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++)
            run_op(i, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

        // start re-asserted at N+5 is ignored; flush at N+10 aborts without a write.
        issue(3'd0, 32'd3, 32'd4, 5'd20);
        wb_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) begin
                bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd9; bus.op_b = 32'd3; bus.rd_in = 5'd21;
            end
            if (k == 10) begin
                chk("ign busy_before_flush", 64'(bus.busy), 64'(1));
                chk("ign state_calc", 64'(dbg_state), 64'(S_CALC));
                bus.flush = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.wb_en) wb_seen++;
        end
        bus.flush = 1'b0;
        chk("flush busy_low", 64'(bus.busy), 64'(0));
        chk("flush state_idle", 64'(dbg_state), 64'(S_IDLE));
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.wb_en) wb_seen++;
        end
        chk("flush no_wb", 64'(wb_seen), 64'(0));
        chk("flush busy_stays_low", 64'(bus.busy), 64'(0));
        chk("flush data_hold", 64'(bus.wb_data), 64'(last_data));
        chk("flush rd_hold", 64'(bus.wb_rd), 64'(last_rd));

        // flush together with start in IDLE: nothing accepted.
        bus.flush = 1'b1;
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9; bus.rd_in = 5'd22;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("fs busy", 64'(bus.busy), 64'(0));
        chk("fs state", 64'(dbg_state), 64'(S_IDLE));

        // flush during DONE suppresses the write strobe and leaves held values alone.
        issue(3'd0, 32'd2, 32'd3, 5'd23);
        wait_done(n);
        chk("fdone latency", 64'(n), 64'(XLEN));
        bus.flush = 1'b1;
        #1;
        chk("fdone wb_en", 64'(bus.wb_en), 64'(0));
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        chk("fdone busy", 64'(bus.busy), 64'(0));
        chk("fdone data_hold", 64'(bus.wb_data), 64'(last_data));
        chk("fdone rd_hold", 64'(bus.wb_rd), 64'(last_rd));

        // rst at N+20 aborts; everything reads zero; the unit then works normally.
        issue(3'd4, 32'd100, 32'd7, 5'd24);
        wb_seen = 0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.wb_en) wb_seen++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst busy", 64'(bus.busy), 64'(0));
        chk("mrst wb_en", 64'(bus.wb_en), 64'(0));
        chk("mrst wb_rd", 64'(bus.wb_rd), 64'(0));
        chk("mrst wb_data", 64'(bus.wb_data), 64'(0));
        chk("mrst state", 64'(dbg_state), 64'(S_IDLE));
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.wb_en) wb_seen++;
        end
        chk("mrst no_wb", 64'(wb_seen), 64'(0));
        run_op(100, 3'd4, 32'd100, 32'd7, 5'd25, 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
